instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Consumer side of the program counter register. Issues instruction-memory reads at the current programCounter over a req/ack handshake and holds each fetched word until decode accepts it.
- Drives the `address` bus that the PC register loads every clock. Stalling therefore means driving `address` = programCounter.
- Applies branch/jump redirects and a vectored interrupt, and records the return address in epc.

Parameters:
- PC_STEP, 1, increment added to programCounter for sequential fetch (word addressing).
- INT_VECTOR, 35, address loaded on an accepted interrupt.
- WIDTH, 32, address and instruction width.

Ports:
- clock  in  1  single clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- programCounter  in  WIDTH  current PC register value.
- address  out  WIDTH  next-PC value; the PC register loads it every clock.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  WIDTH  read address; equals programCounter.
- imem_ack  in  1  one-cycle completion strobe; imem_data valid in the same cycle.
- imem_data  in  WIDTH  read data.
- instr  out  WIDTH  held instruction.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode accepts instr.
- redirect_valid  in  1  one-cycle strobe: branch taken or jump.
- redirect_target  in  WIDTH  redirect destination.
- interrupt  in  1  level interrupt request; rising edge detected.
- epc  out  WIDTH  return address saved on interrupt.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=REQ; imem_req=0 while reset is asserted.
  - instr=0, instr_valid=0, epc=0.
  - pend_redir=0, pend_int=0, int_prev=0.
  - address=programCounter (combinational hold).
- State REQ:
  - imem_req=1, imem_addr=programCounter.
  - address=programCounter until ack, so imem_addr is stable while imem_req=1.
  - The request is never withdrawn except by reset.
- REQ with imem_ack=1:
  - No pending or same-cycle redirect/interrupt: instr<=imem_data, instr_valid<=1, next state HOLD. address=programCounter.
  - Redirect or interrupt pending or arriving: discard data, apply the event (see priority), stay in REQ. A new request goes out next cycle at the new PC.
- State HOLD:
  - imem_req=0, instr_valid=1.
  - instr_ready=1 and no event: address=programCounter+PC_STEP (modulo 2^WIDTH, wraps silently), instr_valid<=0, next state REQ.
  - instr_ready=0 and no event: address=programCounter, instr/instr_valid unchanged.
  - Event in HOLD (pending, or arriving this cycle): squash regardless of instr_ready. instr_valid<=0, address=event target, next state REQ.
- Event capture:
  - redirect_valid sets pend_redir and stores the target in pend_target. The latest redirect wins.
  - A rising edge of interrupt (int_prev sampled each cycle) sets pend_int.
  - Events are applied at the first REQ+ack or HOLD cycle. A same-cycle arriving event is applied directly (combinational bypass).
- Priority when applied: interrupt > redirect > sequential.
  - Interrupt: address=INT_VECTOR.
  - epc<=pending redirect target if a redirect is also pending, else programCounter (the instruction being squashed).
  - pend_int and pend_redir both clear. The redirect is consumed into epc.
  - Redirect only: address=pend_target, pend_redir clears.
- Reset mid-handshake: req drops immediately, and a subsequent imem_ack is ignored after reset deasserts until a new REQ cycle. Memory must tolerate an abandoned request.
- Each imem_addr value is issued at most once per fetch. instr changes only on a cycle where instr_valid rises.

Decomposition:
- Package fetch_pkg: state encoding (REQ, HOLD), WIDTH default, PC_STEP, INT_VECTOR constants.
- One sub-module is natural: next_pc_select. It is combinational priority mux plus adder, taking programCounter, event flags and targets and producing address and epc-next.
- The FSM and event registers stay in instruction_fetch.

Test Plan:
- Reset with PC=0, memory acks every 2 cycles with data 0x100+addr, instr_ready=1 -> instr sequence 0x100,0x101,0x102; address increments 0→1→2; imem_req never high during reset.
- HOLD with instr_ready=0 for 5 cycles at PC=7 -> address=7 throughout; instr unchanged; instr_valid=1; no second request.
- redirect_valid with target 0x40 while in REQ at PC=3 before ack -> ack data discarded; next request imem_addr=0x40; instr_valid never asserted for PC 3.
- Interrupt rising edge with redirect to 0x80 in the same HOLD cycle at PC=12 -> address=35, epc=0x80, instr_valid drops.
- Interrupt in HOLD at PC=12, no redirect -> epc=12, address=35. Interrupt held high 10 cycles -> only one vector taken.
- Wrap: PC=0xFFFFFFFF, accept -> address=0. Reset asserted during REQ -> imem_req=0 same cycle; all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned WIDTH_DEF      = 32;
   localparam int unsigned PC_STEP_DEF    = 1;
   localparam int unsigned INT_VECTOR_DEF = 35;

   // REQ: request outstanding to instruction memory; HOLD: word held for decode.
   typedef enum logic {
      REQ  = 1'b0,
      HOLD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux (interrupt > redirect > sequential > hold) plus the
// return-address selection used when an interrupt is taken.
module next_pc_select
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned PC_STEP    = PC_STEP_DEF,
   parameter int unsigned INT_VECTOR = INT_VECTOR_DEF
) (
   input  logic [WIDTH-1:0] pc,
   input  logic             apply,
   input  logic             advance,
   input  logic             int_any,
   input  logic             redir_any,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] epc_next
);

   // Select the value the PC register loads; events only act on apply cycles.
   always_comb begin
      next_pc  = pc;
      epc_next = redir_any ? target : pc;
      if (apply) begin
         if (int_any) begin
            next_pc = WIDTH'(INT_VECTOR);
         end else if (redir_any) begin
            next_pc = target;
         end else if (advance) begin
            next_pc = pc + WIDTH'(PC_STEP);
         end
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: req/ack read of imem at programCounter, holds the word
// until decode accepts it, and applies redirects and a vectored interrupt.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned PC_STEP    = PC_STEP_DEF,
   parameter int unsigned INT_VECTOR = INT_VECTOR_DEF,
   parameter int unsigned WIDTH      = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] programCounter,
   output logic [WIDTH-1:0] address,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             interrupt,
   output logic [WIDTH-1:0] epc
);

   fetch_state_t     state, state_next;
   logic             req_live;
   logic             pend_redir, pend_int, int_prev;
   logic [WIDTH-1:0] pend_target;
   logic [WIDTH-1:0] epc_next;
   logic             int_rise, int_any, redir_any, event_any;
   logic [WIDTH-1:0] target_eff;
   logic             ack_ok, apply, advance, load_instr, take_event;

   // req_live keeps the request low for one cycle after reset so a stale
   // ack from an abandoned request cannot be mistaken for a new completion.
   assign imem_req  = (state == REQ) && req_live;
   assign imem_addr = programCounter;

   // Pending events merged with same-cycle arrivals; newest redirect wins.
   always_comb begin
      int_rise   = interrupt & ~int_prev;
      int_any    = pend_int | int_rise;
      redir_any  = pend_redir | redirect_valid;
      target_eff = redirect_valid ? redirect_target : pend_target;
      event_any  = int_any | redir_any;
      ack_ok     = imem_req & imem_ack;
      apply      = ack_ok | (state == HOLD);
      advance    = (state == HOLD) & instr_ready;
   end

   next_pc_select #(
      .WIDTH      (WIDTH),
      .PC_STEP    (PC_STEP),
      .INT_VECTOR (INT_VECTOR)
   ) u_next_pc (
      .pc        (programCounter),
      .apply     (apply),
      .advance   (advance),
      .int_any   (int_any),
      .redir_any (redir_any),
      .target    (target_eff),
      .next_pc   (address),
      .epc_next  (epc_next)
   );

   // Next-state logic: capture data on a clean ack, squash on any event.
   always_comb begin
      state_next = state;
      load_instr = 1'b0;
      take_event = 1'b0;
      case (state)
         REQ: begin
            if (ack_ok) begin
               if (event_any) begin
                  take_event = 1'b1;
               end else begin
                  load_instr = 1'b1;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (event_any) begin
               take_event = 1'b1;
               state_next = REQ;
            end else if (instr_ready) begin
               state_next = REQ;
            end
         end
         default: state_next = REQ;
      endcase
   end

   // State, held instruction and return address registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= REQ;
         req_live    <= 1'b0;
         instr       <= '0;
         instr_valid <= 1'b0;
         epc         <= '0;
      end else begin
         state       <= state_next;
         req_live    <= 1'b1;
         instr_valid <= (state_next == HOLD);
         if (load_instr) begin
            instr <= imem_data;
         end
         if (take_event && int_any) begin
            epc <= epc_next;
         end
      end
   end

   // Event capture; applying an event consumes both pending flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_redir  <= 1'b0;
         pend_int    <= 1'b0;
         pend_target <= '0;
         int_prev    <= 1'b0;
      end else begin
         int_prev <= interrupt;
         if (take_event) begin
            pend_redir <= 1'b0;
            pend_int   <= 1'b0;
         end else begin
            if (redirect_valid) begin
               pend_redir  <= 1'b1;
               pend_target <= redirect_target;
            end
            if (int_rise) begin
               pend_int <= 1'b1;
            end
         end
      end
   end

endmodule
